// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Radix-2 shift-add / restoring divide, one bit per clock.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]   count;
  logic [XLEN:0]   accHi, accHiNext;
  logic [XLEN-1:0] accLo, accLoNext;
  logic [XLEN-1:0] opB;
  logic            isDiv, negLo, negHi, divZero;

  logic            signedOp, rsNeg, rtNeg;
  logic [XLEN-1:0] rsMag, rtMag;
  logic [XLEN:0]   mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] prod, prodFix;
  logic [XLEN-1:0] hiFix, loFix;

  // Operand magnitudes and sign flags for the op being launched
  always_comb begin
    signedOp = ~op[0];
    rsNeg    = signedOp & rs_data[XLEN-1];
    rtNeg    = signedOp & rt_data[XLEN-1];
    rsMag    = rsNeg ? -rs_data : rs_data;
    rtMag    = rtNeg ? -rt_data : rt_data;
  end

  // Next state plus one radix-2 step and the final sign correction
  always_comb begin
    stateNext = state;
    accHiNext = accHi;
    accLoNext = accLo;
    mulSum    = accLo[0] ? accHi + {1'b0, opB} : accHi;
    divShift  = {accHi[XLEN-1:0], accLo[XLEN-1]};
    divDiff   = divShift - {1'b0, opB};
    prod      = {accHi[XLEN-1:0], accLo};
    prodFix   = negLo ? -prod : prod;
    hiFix     = prodFix[2*XLEN-1:XLEN];
    loFix     = prodFix[XLEN-1:0];

    if (isDiv) begin
      if (!divDiff[XLEN]) begin
        accHiNext = divDiff;
        accLoNext = {accLo[XLEN-2:0], 1'b1};
      end else begin
        accHiNext = divShift;
        accLoNext = {accLo[XLEN-2:0], 1'b0};
      end
      hiFix = negHi ? -accHi[XLEN-1:0] : accHi[XLEN-1:0];
      loFix = negLo ? -accLo : accLo;
      if (divZero) loFix = '1;
    end else begin
      accHiNext = {1'b0, mulSum[XLEN:1]};
      accLoNext = {mulSum[0], accLo[XLEN-1:1]};
    end

    unique case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (count == CW'(XLEN - 1)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State, datapath and HI/LO registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE);
      done  <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (mthi) hi <= rs_data;
          if (mtlo) lo <= rs_data;
          if (start) begin
            opB     <= op[1] ? rtMag : rsMag;
            accLo   <= op[1] ? rsMag : rtMag;
            accHi   <= '0;
            count   <= '0;
            isDiv   <= op[1];
            negLo   <= rsNeg ^ rtNeg;
            negHi   <= rsNeg;
            divZero <= op[1] & (rt_data == '0);
          end
        end
        RUN: begin
          accHi <= accHiNext;
          accLo <= accLoNext;
          count <= count + CW'(1);
        end
        FIX: begin
          hi <= hiFix;
          lo <= loFix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus
// hand sequences for the multi-cycle corner cases.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nChecks = 0;
  int nFail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_data(rsData),
    .rt_data(rtData),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eHi;
    logic [31:0] eLo;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runOp(input vec_t v);
    int busyErr;
    start  = 1'b1;
    op     = v.op;
    rsData = v.a;
    rtData = v.b;
    tick();
    start  = 1'b0;
    rsData = $urandom;
    rtData = $urandom;
    busyErr = 0;
    if (busy !== 1'b1) busyErr++;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (busy !== 1'b1 || done !== 1'b0) busyErr++;
    end
    tick();
    check({v.name, " busy33"}, 32'(busyErr), 32'd0);
    check({v.name, " done"}, {31'd0, done}, 32'd1);
    check({v.name, " busy0"}, {31'd0, busy}, 32'd0);
    check({v.name, " hi"}, hi, v.eHi);
    check({v.name, " lo"}, lo, v.eLo);
    tick();
    check({v.name, " done1cyc"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5"};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, "mult_min2"};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
    vecs[4]  = '{2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_by0"};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_ovf"};
    vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_m7by0"};
    vecs[7]  = '{2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, "multu_shift"};
    vecs[8]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100d7"};
    vecs[9]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_7dm2"};
    vecs[10] = '{2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "mult_7xm1"};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, "divu_maxd1"};
    vecs[12] = '{2'b00, 32'd0, 32'hFFFFFFFB, 32'h0, 32'h0, "mult_0xm5"};

    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rsData = 32'h0;
    rtData = 32'h0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);

    foreach (vecs[i]) runOp(vecs[i]);

    // mthi then mtlo in consecutive idle cycles
    mthi = 1'b1; rsData = 32'h1234;
    tick();
    mthi = 1'b0; mtlo = 1'b1; rsData = 32'hABCD;
    tick();
    mtlo = 1'b0;
    check("mthi hi", hi, 32'h1234);
    check("mtlo lo", lo, 32'hABCD);
    check("mtx busy", {31'd0, busy}, 32'd0);

    // start and mtlo while busy are both ignored
    start = 1'b1; op = 2'b11; rsData = 32'd100; rtData = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; op = 2'b01; rsData = 32'h55; rtData = 32'd2; mtlo = 1'b1;
    tick();
    start = 1'b0; mtlo = 1'b0;
    check("busy mtlo ign", lo, 32'hABCD);
    repeat (22) tick();
    tick();
    check("ign done", {31'd0, done}, 32'd1);
    check("ign lo", lo, 32'd14);
    check("ign hi", hi, 32'd2);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("no queued op", 32'(pulses), 32'd0);

    // mthi and mtlo together
    mthi = 1'b1; mtlo = 1'b1; rsData = 32'h77;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("both hi", hi, 32'h77);
    check("both lo", lo, 32'h77);

    // start with mthi in the same idle cycle
    start = 1'b1; mthi = 1'b1; op = 2'b01; rsData = 32'd9; rtData = 32'd3;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("st+mthi hi", hi, 32'd9);
    repeat (32) tick();
    tick();
    check("st+mthi done", {31'd0, done}, 32'd1);
    check("st+mthi rhi", hi, 32'd0);
    check("st+mthi rlo", lo, 32'd27);

    // back-to-back: start accepted in the done cycle
    tick();
    start = 1'b1; op = 2'b01; rsData = 32'd6; rtData = 32'd7;
    tick();
    start = 1'b0;
    repeat (32) tick();
    tick();
    check("b2b done1", {31'd0, done}, 32'd1);
    check("b2b lo1", lo, 32'd42);
    start = 1'b1; op = 2'b11; rsData = 32'd50; rtData = 32'd8;
    tick();
    start = 1'b0;
    check("b2b busy2", {31'd0, busy}, 32'd1);
    check("b2b ndone", {31'd0, done}, 32'd0);
    repeat (32) tick();
    tick();
    check("b2b done2", {31'd0, done}, 32'd1);
    check("b2b lo2", lo, 32'd6);
    check("b2b hi2", hi, 32'd2);

    // reset mid-operation
    tick();
    mthi = 1'b1; mtlo = 1'b1; rsData = 32'hDEAD;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'b01; rsData = 32'd3; rtData = 32'd4;
    tick();
    start = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst busy", {31'd0, busy}, 32'd0);
    check("mrst hi", hi, 32'h0);
    check("mrst lo", lo, 32'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) pulses++;
    end
    check("mrst nodone", 32'(pulses), 32'd0);
    check("mrst hi2", hi, 32'h0);
    runOp('{2'b11, 32'd9, 32'd3, 32'd0, 32'd3, "divu_9d3"});

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
